// File: rtl/iic_slave_regs.sv
// iic_slave_regs: I2C target with a DEPTH x 8-bit register file.
// Samples SCL/SDA on pclk, detects START/STOP, matches SLAVE_ADDR, ACKs,
// handles pointer-based writes and sequential reads. SDA is driven
// open-drain through sda_oe only; SCL is never driven (no stretching).
// Optional feature macro: IIC_SLAVE_GLITCH_FILTER_EN adds a 3-sample
// majority filter on the synchronized SCL/SDA (one extra cycle of latency,
// single-cycle pulses rejected).
module iic_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int          DEPTH      = 16,
    localparam int         PW         = $clog2(DEPTH)
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_stb,
    output logic [PW-1:0] wr_ptr,
    output logic [7:0]    wr_data,
    input  logic [PW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_BYTE  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    // Cycles until sync, history and delayed-copy flops all hold real bus levels.
    localparam logic [2:0] PRIME_CYC = 3'd5;
`else
    localparam logic [2:0] PRIME_CYC = 3'd3;
`endif

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic          r_scl_d, r_sda_d;
    logic [2:0]    r_prime;
    logic          w_scl, w_sda, w_live;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]    w_byte;

    logic [2:0]    r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [PW-1:0] r_ptr;
    logic          r_rw;
    logic          r_first;
    logic          r_ack_on;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_wr_stb;
    logic [PW-1:0] r_wr_ptr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_mem [DEPTH];

    // Two-flop synchronizer; idles high like the pulled-up bus.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    logic r_scl_h1, r_scl_h2, r_sda_h1, r_sda_h2;

    // Sample history for the majority filter.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_scl_h1 <= 1'b1;
            r_scl_h2 <= 1'b1;
            r_sda_h1 <= 1'b1;
            r_sda_h2 <= 1'b1;
        end else begin
            r_scl_h1 <= r_scl_s2;
            r_scl_h2 <= r_scl_h1;
            r_sda_h1 <= r_sda_s2;
            r_sda_h2 <= r_sda_h1;
        end
    end

    assign w_scl = maj3(r_scl_s2, r_scl_h1, r_scl_h2);
    assign w_sda = maj3(r_sda_s2, r_sda_h1, r_sda_h2);
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    // Delayed copy for edge detection plus a priming counter so the reset
    // values of the pipeline can never be mistaken for a bus START/STOP.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
            r_prime <= 3'd0;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
            if (r_prime != PRIME_CYC) begin
                r_prime <= r_prime + 3'd1;
            end else begin
                r_prime <= r_prime;
            end
        end
    end

    assign w_live     = (r_prime == PRIME_CYC);
    assign w_scl_rise = w_live &  w_scl & ~r_scl_d;
    assign w_scl_fall = w_live & ~w_scl &  r_scl_d;
    assign w_start    = w_live &  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
    assign w_stop     = w_live &  w_scl &  r_scl_d & ~r_sda_d &  w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    // Protocol FSM, register file and write-strobe outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= {PW{1'b0}};
            r_rw      <= 1'b0;
            r_first   <= 1'b0;
            r_ack_on  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_ptr  <= {PW{1'b0}};
            r_wr_data <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                // START or repeated START; pointer is kept on purpose.
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_ack_on  <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_ack_on  <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_ack_on  <= 1'b0;
                                if (r_shift[6:0] == SLAVE_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                    r_rw    <= w_sda;
                                end else begin
                                    r_state <= ST_IGNORE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // First fall (8th SCL) asserts ACK, second fall (9th) ends it.
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_ack_on <= 1'b0;
                                if (r_rw) begin
                                    r_state   <= ST_RD_BYTE;
                                    r_sda_oe  <= ~r_mem[r_ptr][7];
                                    r_shift   <= {r_mem[r_ptr][6:0], 1'b0};
                                    r_bit_cnt <= 4'd1;
                                end else begin
                                    r_state   <= ST_WR_BYTE;
                                    r_sda_oe  <= 1'b0;
                                    r_first   <= 1'b1;
                                    r_bit_cnt <= 4'd0;
                                end
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                r_ack_on  <= 1'b0;
                                r_state   <= ST_WR_ACK;
                                if (r_first) begin
                                    r_first <= 1'b0;
                                    r_ptr   <= w_byte[PW-1:0];
                                end else begin
                                    r_mem[r_ptr] <= w_byte;
                                    r_wr_stb     <= 1'b1;
                                    r_wr_ptr     <= r_ptr;
                                    r_wr_data    <= w_byte;
                                    r_ptr        <= r_ptr + PTR_ONE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_ack_on <= 1'b0;
                                r_state  <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        // r_bit_cnt counts bits already placed on SDA.
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_ack_on <= 1'b0;
                                r_state  <= ST_RD_ACK;
                            end else begin
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // r_ack_on here means "master ACKed, next fall starts a byte".
                        if (w_scl_rise) begin
                            r_ptr <= r_ptr + PTR_ONE;
                            if (w_sda) begin
                                r_state <= ST_IGNORE;
                            end else begin
                                r_ack_on <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_on) begin
                            r_ack_on  <= 1'b0;
                            r_state   <= ST_RD_BYTE;
                            r_sda_oe  <= ~r_mem[r_ptr][7];
                            r_shift   <= {r_mem[r_ptr][6:0], 1'b0};
                            r_bit_cnt <= 4'd1;
                        end
                    end
                    ST_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_stb   = r_wr_stb;
    assign wr_ptr   = r_wr_ptr;
    assign wr_data  = r_wr_data;
    assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed + randomized bench for iic_slave_regs. The bench acts as the I2C
// master and keeps a transaction-level model of the register file.
module tb_iic_slave_regs;

    logic       pclk = 1'b0;
    logic       preset;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, busy, wr_stb;
    logic [3:0] wr_ptr, dbg_addr;
    logic [7:0] wr_data, dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  model_mem [16];
    int          model_ptr;
    logic [11:0] exp_wr [$];
    logic [11:0] obs_wr [$];
    int          obs_idx = 0;
    int          oe_cnt = 0;
    int          busy_cnt = 0;
    logic [7:0]  wbuf [8];

    assign sda_bus = sda_m & ~sda_oe;

    iic_slave_regs #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
        .pclk(pclk), .preset(preset), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .busy(busy), .wr_stb(wr_stb), .wr_ptr(wr_ptr),
        .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 pclk = ~pclk;

    // Bus monitor: record write strobes and count SDA drive / busy cycles.
    always @(posedge pclk) begin
        if (wr_stb) obs_wr.push_back({wr_ptr, wr_data});
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(8);
        sda_m = 1'b0; wait_clk(8);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_clk(6);
        scl_m = 1'b1; wait_clk(6);
        sda_m = 1'b0; wait_clk(6);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(6);
        scl_m = 1'b1; wait_clk(6);
        sda_m = 1'b1; wait_clk(8);
    endtask

    // One SCL period, SCL low on entry and exit; returns SDA seen mid-high.
    task automatic bit_cycle(input logic b, input logic glitch, output logic r);
        sda_m = b; wait_clk(6);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clk(3); scl_m = 1'b0; wait_clk(1); scl_m = 1'b1; wait_clk(1);
        end else begin
            wait_clk(4);
        end
        r = sda_bus; wait_clk(4);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], (i == glitch_bit), r);
        bit_cycle(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic last, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, 1'b0, r);
            d[i] = r;
        end
        bit_cycle(last, 1'b0, r);
    endtask

    task automatic check_wr_events();
        check("wr_stb_count", obs_wr.size() - obs_idx, exp_wr.size());
        foreach (exp_wr[i]) begin
            if (obs_idx < obs_wr.size()) begin
                check("wr_stb_ptr_data", obs_wr[obs_idx], exp_wr[i]);
                obs_idx++;
            end
        end
        exp_wr.delete();
        obs_idx = obs_wr.size();
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            check(tag, {i[7:0], dbg_data}, {i[7:0], model_mem[i]});
        end
    endtask

    // Write transaction: wbuf[0] is the pointer, wbuf[1..n] the data.
    task automatic xfer_write(input logic [6:0] addr, input int n, input int glitch_bit);
        logic ack;
        logic hit;
        hit = (addr == 7'h50);
        bus_start();
        write_byte({addr, 1'b0}, -1, ack);
        check("wr_addr_ack", ack, hit);
        write_byte(wbuf[0], -1, ack);
        check("wr_ptr_ack", ack, hit);
        if (hit) model_ptr = int'(wbuf[0][3:0]);
        for (int i = 1; i <= n; i++) begin
            write_byte(wbuf[i], (i == 1) ? glitch_bit : -1, ack);
            check("wr_data_ack", ack, hit);
            if (hit) begin
                model_mem[model_ptr] = wbuf[i];
                exp_wr.push_back({4'(model_ptr), wbuf[i]});
                model_ptr = (model_ptr + 1) % 16;
            end
        end
        bus_stop();
        check_wr_events();
    endtask

    // Read n bytes, optionally setting the pointer first with a repeated START.
    task automatic xfer_read(input int n, input logic set_ptr, input logic [7:0] p);
        logic ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            write_byte(8'hA0, -1, ack);
            check("rd_waddr_ack", ack, 1'b1);
            write_byte(p, -1, ack);
            check("rd_ptr_ack", ack, 1'b1);
            model_ptr = int'(p[3:0]);
            bus_rstart();
        end
        write_byte(8'hA1, -1, ack);
        check("rd_addr_ack", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check("rd_data", d, model_mem[model_ptr]);
            model_ptr = (model_ptr + 1) % 16;
        end
        bus_stop();
    endtask

    initial begin
        logic [7:0] d;
        logic       ack;
        logic       r;
        int         oe0, busy0, n, p;

        scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 4'd0;
        preset = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
        wait_clk(4);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_ptr", wr_ptr, 4'd0);
        check("rst_wr_data", wr_data, 8'h00);
        check_mem("rst_mem");
        preset = 1'b0;
        wait_clk(10);

        // Plain write of two bytes at pointer 3.
        wbuf[0] = 8'h03; wbuf[1] = 8'hA5; wbuf[2] = 8'h5A;
        xfer_write(7'h50, 2, -1);
        check_mem("mem_after_wr");

        // Pointer write, repeated START, two-byte read; then one more read.
        xfer_read(2, 1'b1, 8'h03);
        xfer_read(1, 1'b0, 8'h00);

        // Foreign address: no drive, no busy, no memory change.
        oe0 = oe_cnt; busy0 = busy_cnt;
        wbuf[0] = 8'h01; wbuf[1] = 8'hEE;
        xfer_write(7'h51, 1, -1);
        check("nomatch_oe_cycles", oe_cnt - oe0, 0);
        check("nomatch_busy_cycles", busy_cnt - busy0, 0);
        check_mem("mem_after_nomatch");

        // Pointer wrap at the top of the file.
        wbuf[0] = 8'h0F; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        xfer_write(7'h50, 2, -1);
        xfer_read(3, 1'b1, 8'h0E);

        // Reset during the 4th data bit of a read of 0xA5 (that bit is 0).
        bus_start();
        write_byte(8'hA0, -1, ack);
        write_byte(8'h03, -1, ack);
        bus_rstart();
        write_byte(8'hA1, -1, ack);
        check("rstrd_addr_ack", ack, 1'b1);
        for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b0, r);
        sda_m = 1'b1; wait_clk(6);
        scl_m = 1'b1; wait_clk(2);
        check("rstrd_oe_before", sda_oe, 1'b1);
        check("rstrd_busy_before", busy, 1'b1);
        @(posedge pclk); #1 preset = 1'b1;
        @(negedge pclk);
        check("rstrd_oe_after", sda_oe, 1'b0);
        check("rstrd_busy_after", busy, 1'b0);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
        check_mem("rstrd_mem");
        preset = 1'b0;
        wait_clk(2); scl_m = 1'b0; wait_clk(2);
        bus_stop();
        check("rstrd_oe_idle", sda_oe, 1'b0);
        wbuf[0] = 8'h06; wbuf[1] = 8'hC3; wbuf[2] = 8'h3C;
        xfer_write(7'h50, 2, -1);
        xfer_read(2, 1'b1, 8'h06);

        // Randomized write/read-back transactions against the model.
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, 15);
            n = $urandom_range(1, 4);
            wbuf[0] = 8'(p);
            for (int i = 1; i <= n; i++) wbuf[i] = 8'($urandom_range(0, 255));
            xfer_write(7'h50, n, -1);
            xfer_read(n, 1'b1, 8'(p));
        end
        check_mem("mem_after_random");

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
        // One-cycle SCL low glitch inside bit 4 of a data byte is filtered out.
        wbuf[0] = 8'h07; wbuf[1] = 8'h96;
        xfer_write(7'h50, 1, 4);
        check_mem("mem_after_glitch");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
